// File: rtl/rx_cmd_parser.sv
// rx_cmd_parser: assembles UART bytes into 5-byte command frames
// (SYNC, ACTION, ARG_H, ARG_L, CHK), validates them, publishes the accepted
// action/argument and drives a link-loss failsafe from a frame watchdog.
//
// Byte interface: rx_valid is a one-cycle strobe qualifying rx_data. There is
// no ready signal; every strobe is consumed in the cycle it arrives, including
// strobes on consecutive cycles.
module rx_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned BYTE_TIMEOUT = 50000,
    parameter int unsigned WDOG_CYCLES  = 25000000,
    parameter logic [7:0]  ACT_MAX      = 8'h03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  cmd_action,
    output logic [15:0] cmd_arg,
    output logic        cmd_valid,
    output logic        err_pulse,
    output logic [7:0]  err_count,
    output logic        link_lost
);

    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_END  = WD_W'(WDOG_CYCLES);

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_ACT  = 3'd1,
        ST_ARGH = 3'd2,
        ST_ARGL = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    state_t          state;
    logic [7:0]      act_q;
    logic [7:0]      argh_q;
    logic [7:0]      argl_q;
    logic [BT_W-1:0] byte_cnt;
    logic [WD_W-1:0] wdog_cnt;

    logic frame_ok;
    logic accept;
    logic byte_timeout;
    logic wdog_expire;

    // Frame verdict, inter-byte timeout and watchdog expiry for this cycle.
    // A byte arriving on the expiry cycle takes priority over the timeout,
    // and an accept takes priority over watchdog expiry.
    always_comb begin
        frame_ok     = ((act_q ^ argh_q ^ argl_q) == rx_data) &&
                       (act_q >= 8'h01) && (act_q <= ACT_MAX);
        accept       = rx_valid && (state == ST_CHK) && frame_ok;
        byte_timeout = !rx_valid && (state != ST_HUNT) && (byte_cnt == BT_LAST);
        wdog_expire  = !accept && (wdog_cnt == WD_LAST);
    end

    // Inter-byte timer: cleared by every byte, runs only inside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
        end else if (rx_valid || byte_timeout || (state == ST_HUNT)) begin
            byte_cnt <= '0;
        end else begin
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    // Frame watchdog: reloads on accept, otherwise counts up and holds at
    // its terminal value while the link is declared lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt  <= '0;
            link_lost <= 1'b0;
        end else if (accept) begin
            wdog_cnt  <= '0;
            link_lost <= 1'b0;
        end else if (wdog_cnt != WD_END) begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_expire) begin
                link_lost <= 1'b1;
            end
        end
    end

    // Frame FSM with its field registers and the registered command/error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            act_q      <= 8'h00;
            argh_q     <= 8'h00;
            argl_q     <= 8'h00;
            cmd_action <= 8'h00;
            cmd_arg    <= 16'h0000;
            cmd_valid  <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            cmd_valid <= 1'b0;
            err_pulse <= 1'b0;

            if (byte_timeout) begin
                state     <= ST_HUNT;
                err_pulse <= 1'b1;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (rx_valid) begin
                case (state)
                    ST_HUNT: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= ST_ACT;
                        end
                    end
                    ST_ACT: begin
                        act_q <= rx_data;
                        state <= ST_ARGH;
                    end
                    ST_ARGH: begin
                        argh_q <= rx_data;
                        state  <= ST_ARGL;
                    end
                    ST_ARGL: begin
                        argl_q <= rx_data;
                        state  <= ST_CHK;
                    end
                    ST_CHK: begin
                        state <= ST_HUNT;
                        if (frame_ok) begin
                            cmd_action <= act_q;
                            cmd_arg    <= {argh_q, argl_q};
                            cmd_valid  <= 1'b1;
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end

            // Entering link loss forces the land/idle command, announced once.
            if (wdog_expire) begin
                cmd_action <= 8'h00;
                cmd_arg    <= 16'h0000;
                cmd_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_cmd_parser.sv
// tb_rx_cmd_parser: directed checks of frame acceptance/rejection, byte
// timeout, watchdog link loss, error saturation and asynchronous reset.
module tb_rx_cmd_parser;

  localparam int BT = 20;
  localparam int WD = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  cmd_action;
  logic [15:0] cmd_arg;
  logic        cmd_valid;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic        link_lost;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  rx_cmd_parser #(
    .SYNC_BYTE(SYNC),
    .BYTE_TIMEOUT(BT),
    .WDOG_CYCLES(WD),
    .ACT_MAX(8'h03)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .cmd_action(cmd_action),
    .cmd_arg(cmd_arg),
    .cmd_valid(cmd_valid),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .link_lost(link_lost)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks: called at a negedge, return at the negedge after the strobe
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] c);
    send_byte(SYNC);
    send_byte(a);
    send_byte(h);
    send_byte(l);
    send_byte(c);
  endtask

  // scoreboard: every cmd_valid pulse must match the next expected command word
  always @(negedge clk) begin
    if (rst_n && cmd_valid) begin
      check("cmd_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("cmd_word", {8'h00, cmd_action, cmd_arg}, {8'h00, e});
      end
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int pulses;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_action", cmd_action, 0);
    check("rst_arg", cmd_arg, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_link_lost", link_lost, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // valid frame
    exp_q.push_back({8'h02, 16'h03E8});
    send_frame(8'h02, 8'h03, 8'hE8, 8'hE9);
    check("ok1_valid", cmd_valid, 1);
    check("ok1_action", cmd_action, 8'h02);
    check("ok1_arg", cmd_arg, 16'h03E8);
    check("ok1_err_count", err_count, 0);
    check("ok1_err_pulse", err_pulse, 0);
    @(negedge clk);
    check("ok1_valid_one_cycle", cmd_valid, 0);

    // bad checksum
    send_frame(8'h01, 8'h00, 8'h10, 8'h00);
    check("badchk_err_pulse", err_pulse, 1);
    check("badchk_valid", cmd_valid, 0);
    check("badchk_err_count", err_count, 1);
    check("badchk_action_kept", cmd_action, 8'h02);
    check("badchk_arg_kept", cmd_arg, 16'h03E8);
    @(negedge clk);
    check("badchk_pulse_one_cycle", err_pulse, 0);
    exp_q.push_back({8'h01, 16'h0010});
    send_frame(8'h01, 8'h00, 8'h10, 8'h11);
    check("ok2_valid", cmd_valid, 1);
    check("ok2_action", cmd_action, 8'h01);
    check("ok2_arg", cmd_arg, 16'h0010);

    // illegal action
    send_frame(8'h07, 8'h00, 8'h00, 8'h07);
    check("badact_err_pulse", err_pulse, 1);
    check("badact_err_count", err_count, 2);
    check("badact_action_kept", cmd_action, 8'h01);

    // leading garbage is discarded silently
    send_byte(8'h11);
    send_byte(8'h22);
    check("garbage_no_err", err_pulse, 0);
    exp_q.push_back({8'h03, 16'h0000});
    send_frame(8'h03, 8'h00, 8'h00, 8'h03);
    check("ok3_valid", cmd_valid, 1);
    check("ok3_action", cmd_action, 8'h03);
    check("ok3_err_count", err_count, 2);

    // sync value inside a frame is plain data
    exp_q.push_back({8'h01, 16'hA500});
    send_frame(8'h01, 8'hA5, 8'h00, 8'hA4);
    check("resync_valid", cmd_valid, 1);
    check("resync_arg", cmd_arg, 16'hA500);

    // byte timeout after A5 01
    send_byte(SYNC);
    send_byte(8'h01);
    repeat (BT - 1) @(negedge clk);
    check("to_not_yet", err_pulse, 0);
    @(negedge clk);
    check("to_err_pulse", err_pulse, 1);
    check("to_err_count", err_count, 3);
    @(negedge clk);
    check("to_pulse_one_cycle", err_pulse, 0);
    exp_q.push_back({8'h02, 16'h0007});
    send_frame(8'h02, 8'h00, 8'h07, 8'h05);
    check("to_back_in_hunt", cmd_valid, 1);

    // byte on the expiry cycle wins over the timeout
    send_byte(SYNC);
    send_byte(8'h03);
    repeat (BT - 1) @(negedge clk);
    send_byte(8'h00);
    check("late_byte_no_err", err_pulse, 0);
    check("late_byte_err_count", err_count, 3);
    exp_q.push_back({8'h03, 16'h0005});
    send_byte(8'h05);
    send_byte(8'h06);
    check("late_frame_valid", cmd_valid, 1);
    check("late_frame_arg", cmd_arg, 16'h0005);
    check("late_frame_err_count", err_count, 3);

    // watchdog: silence after accepted action 03
    exp_q.push_back({8'h00, 16'h0000});
    repeat (WD - 1) @(negedge clk);
    check("wd_not_yet", link_lost, 0);
    @(negedge clk);
    check("wd_link_lost", link_lost, 1);
    check("wd_valid", cmd_valid, 1);
    check("wd_action", cmd_action, 8'h00);
    check("wd_arg", cmd_arg, 16'h0000);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (cmd_valid) pulses++;
    end
    check("wd_single_pulse", pulses, 0);
    check("wd_held", link_lost, 1);
    exp_q.push_back({8'h03, 16'h1234});
    send_frame(8'h03, 8'h12, 8'h34, 8'h25);
    check("wd_recover_link", link_lost, 0);
    check("wd_recover_valid", cmd_valid, 1);
    check("wd_recover_action", cmd_action, 8'h03);
    check("wd_recover_arg", cmd_arg, 16'h1234);

    // saturation (watchdog expires again during this burst)
    exp_q.push_back({8'h00, 16'h0000});
    for (int i = 0; i < 251; i++) send_frame(8'h01, 8'h00, 8'h10, 8'h00);
    check("sat_254", err_count, 8'd254);
    send_frame(8'h01, 8'h00, 8'h10, 8'h00);
    check("sat_255", err_count, 8'd255);
    for (int i = 0; i < 8; i++) send_frame(8'h01, 8'h00, 8'h10, 8'h00);
    check("sat_hold", err_count, 8'd255);
    check("sat_pulse_still", err_pulse, 1);
    check("sat_link_lost", link_lost, 1);

    // asynchronous reset mid-frame
    send_byte(SYNC);
    send_byte(8'h02);
    #2 rst_n = 1'b0;
    #1;
    check("arst_err_count", err_count, 0);
    check("arst_link_lost", link_lost, 0);
    check("arst_action", cmd_action, 0);
    check("arst_arg", cmd_arg, 0);
    check("arst_valid", cmd_valid, 0);
    check("arst_err_pulse", err_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({8'h02, 16'h0000});
    send_frame(8'h02, 8'h00, 8'h00, 8'h02);
    check("post_rst_valid", cmd_valid, 1);
    check("post_rst_action", cmd_action, 8'h02);
    check("post_rst_err_count", err_count, 0);

    // final report
    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_cmd_parser.md
Name: rx_cmd_parser

Overview:
- Sits between the UART byte receiver and the flight-control target mapper.
- Assembles received bytes into fixed 5-byte command frames and checks sync, action code and checksum.
- Publishes a validated action code and 16-bit argument to the target mapper.
- Raises a link-loss failsafe when no valid frame arrives within a watchdog window.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame.
- BYTE_TIMEOUT, 50000, max clk cycles between consecutive bytes inside a frame (1 ms at 50 MHz).
- WDOG_CYCLES, 25000000, max clk cycles between valid frames before link loss (0.5 s at 50 MHz).
- ACT_MAX, 8'h03, highest legal action code; legal range is 8'h01..ACT_MAX.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- cmd_action  out  8  last accepted action code
- cmd_arg  out  16  last accepted argument, {ARG_H, ARG_L}, unsigned
- cmd_valid  out  1  one-cycle pulse when cmd_action/cmd_arg update
- err_pulse  out  1  one-cycle pulse on any frame rejection
- err_count  out  8  saturating count of rejected frames
- link_lost  out  1  high while the watchdog is expired

Behaviour:
- Reset: clk and rst_n as listed; reset is asynchronous, active-low.
- Values under reset: all outputs 0, FSM in HUNT, both timers cleared.
- Frame format: SYNC, ACTION, ARG_H, ARG_L, CHK.
- Checksum rule: CHK = ACTION ^ ARG_H ^ ARG_L.
- FSM states: HUNT, ACT, ARGH, ARGL, CHK.
  - HUNT: rx_valid with rx_data==SYNC_BYTE -> ACT. Any other byte is discarded silently (no error).
  - ACT: on byte, latch action -> ARGH.
  - ARGH: on byte, latch high argument byte -> ARGL.
  - ARGL: on byte, latch low argument byte -> CHK.
  - CHK: on byte, evaluate the frame, then -> HUNT regardless of outcome.
- Frame evaluation:
  - Accept if the checksum matches and 8'h01 <= action <= ACT_MAX.
  - Bad checksum or illegal action: reject. Outputs keep their old values.
- Accept timing: on the clock edge after the CHK byte's rx_valid cycle:
  - cmd_action and cmd_arg update;
  - cmd_valid pulses for 1 cycle;
  - the watchdog reloads.
  - Latency from CHK byte strobe to cmd_valid is 1 cycle.
- Reject timing: err_pulse high for 1 cycle, at the same latency as an accept.
- err_count: increments by 1 on each rejection and saturates at 255; it never wraps.
- Byte timeout:
  - Inter-byte counter clears on every rx_valid and counts while the FSM is in ACT..CHK.
  - Reaching BYTE_TIMEOUT: FSM -> HUNT, err_pulse, err_count++.
  - Not counted in HUNT.
- Simultaneous rx_valid and timeout expiry: the byte wins. It is consumed, the counter clears, and no timeout error is raised.
- Re-sync: a SYNC_BYTE received mid-frame is treated as data, not as a restart. Only the checksum or timeout path recovers framing.
- Watchdog:
  - Free-running counter, reloaded only by accepted frames.
  - At WDOG_CYCLES it holds and link_lost goes high.
  - While link_lost is high, cmd_action is forced to 8'h00 (land/idle) and cmd_arg to 0. cmd_valid pulses once on entry to link loss.
  - The next accepted frame clears link_lost in the same cycle as its cmd_valid.
  - An accept and watchdog expiry in the same cycle: the accept wins and link_lost stays low.
  - At reset link_lost is 0 and the watchdog starts counting from 0, so link loss asserts WDOG_CYCLES after reset if no frame arrives.
- Reset mid-frame: FSM to HUNT immediately; partially received bytes are discarded.
- Output stability: cmd_action and cmd_arg change only on cmd_valid cycles and are stable otherwise.
- No backpressure: rx_valid strobes are never dropped. Minimum byte spacing is ≥1 cycle; back-to-back strobes on consecutive cycles must be handled.

Test Plan:
- Valid frame: A5 02 03 E8 E9 -> cmd_valid 1 cycle after E9 strobe; cmd_action=02, cmd_arg=16'h03E8; err_count=0.
- Bad checksum: A5 01 00 10 00 -> err_pulse once; err_count=1; cmd_action/cmd_arg unchanged. Then A5 01 00 10 11 -> accepted, action 01, arg 0010.
- Illegal action: A5 07 00 00 07 -> rejected (err_count+1). Leading garbage 11 22 A5 03 00 00 03 -> only the 03 frame is accepted and garbage adds no errors.
- Byte timeout: A5 01, then idle BYTE_TIMEOUT cycles -> FSM HUNT, err_pulse. Byte arriving exactly on the expiry cycle -> no error, frame continues. Bench uses BYTE_TIMEOUT=20.
- Watchdog: WDOG_CYCLES=100, accepted action 03 then silence -> at 100 cycles link_lost=1, cmd_action=00, cmd_arg=0, single cmd_valid. Next valid frame -> link_lost=0 with new values.
- Saturation/reset: 260 bad frames -> err_count holds at 255. rst_n low mid-frame after A5 02 -> all outputs 0; post-reset frame A5 02 00 00 02 is accepted normally.
